psr_bank: RTL and testbench
===========================

PSR_BANK -- requirements
Module: psr_bank

Interface
REQ-001 SHALL have parameters: NUM_BANKS, default 4, number of exception banks (bank 0 = user, no SPSR); DEPTH_W, default 3, nest-depth counter width; BW = $clog2(NUM_BANKS+1), derived.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have: en  in  1  global advance; state holds when 0.
REQ-005 SHALL have: i_exc_req  in  1  exception entry; i_exc_bank  in  BW  target bank; i_exc_fmask  in  1  also set F on entry.
REQ-006 SHALL have: i_exc_ret  in  1  exception return (restore CPSR from current SPSR).
REQ-007 SHALL have: i_nzcv_flag  in  1  ALU flag update; i_nzcv_alu  in  4  ALU NZCV.
REQ-008 SHALL have: i_xpsr_en_ex  in  1  MSR write; i_xpsr_sel  in  1  0=CPSR 1=SPSR; i_xpsr_field  in  2  [1]=flags, [0]=control; i_xpsr_reg  in  32  write data.
REQ-009 SHALL have: o_xpsr_reg  out  32  MRS read; o_nzcv / o_nzcv_next  out  4  current / next-cycle flags; o_irq_mask, o_fiq_mask  out  1; o_bank  out  BW; o_int_mode  out  1 (o_bank!=0); o_depth  out  DEPTH_W; o_err  out  1 sticky.

Function
REQ-010 PSR layout SHALL be {N,Z,C,V, 20'b0, I, F, 1'b0, MODE[4:0]}; MODE = MODE_CODE[bank].
REQ-011 CPSR SHALL hold nzcv, I, F, bank; each bank 1..NUM_BANKS SHALL hold its own SPSR {nzcv, I, F, saved bank}.
REQ-012 nzcv_next SHALL be combinational: MSR CPSR flags-field data if written, else i_nzcv_alu if i_nzcv_flag, else nzcv.
REQ-013 Control-state priority per enabled cycle SHALL be: valid entry > return > MSR control write.
REQ-014 Valid entry (1<=i_exc_bank<=NUM_BANKS): SPSR[i_exc_bank] <= {nzcv_next, I, F, bank} using that cycle's CPSR control state; I<=1; F<=1 if i_exc_fmask else hold; bank<=i_exc_bank; nzcv<=nzcv_next; depth+1 saturating at all-ones (saturation sets o_err).
REQ-015 Invalid entry bank (0 or >NUM_BANKS) SHALL change nothing except setting o_err.
REQ-016 Return with bank!=0: CPSR (nzcv, I, F, bank) <= SPSR[bank] entirely; same-cycle ALU/MSR updates to CPSR dropped; depth-1 unless 0 (depth 0 sets o_err); with bank==0: ignored, o_err set.
REQ-017 Entry and return in same cycle: entry performed, return dropped, o_err unchanged.
REQ-018 MSR CPSR control field: I<=data[7], F<=data[6], bank<=index whose MODE_CODE matches data[4:0]; unmatched code leaves bank unchanged and sets o_err.
REQ-019 MSR SPSR SHALL write the selected fields of SPSR[bank]; when bank==0, write ignored.
REQ-020 MRS: o_xpsr_reg SHALL be CPSR when i_xpsr_sel=0, SPSR[bank] when 1; SPSR read in bank 0 returns CPSR.
REQ-021 Entry into bank b while already in b SHALL overwrite SPSR[b] (no stacking); depth still increments.
REQ-022 All outputs other than o_nzcv_next and o_xpsr_reg SHALL be registered; CPSR update visible one cycle after en-qualified edge.

Reset
REQ-023 On rst_n=0 at clk edge: nzcv=0, I=1, F=1, bank=0, depth=0, o_err=0; every SPSR = {0000, I=1, F=1, bank 0}; reset SHALL override en and any pending request.

Structure
REQ-024 Shared package psr_pkg SHALL hold MODE_CODE table (user 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011), PSR bit-position constants, field-mask constants.
REQ-025 One sub-module psr_mode_dec SHALL map 5-bit mode code to bank index plus valid flag.

Verification
REQ-026 Reset, then MRS CPSR -> 0x000000D0, o_bank=0, o_irq_mask=1, o_fiq_mask=1.
REQ-027 MSR CPSR 0xA0000010 fields=11, then entry bank 2 with i_nzcv_flag=1, alu=0101 same cycle -> SPSR[2]=0x50000010, CPSR=0x50000092, depth=1.
REQ-028 Nested entry bank 1 (fmask=1) from bank 2, return, return -> CPSR sequence 0x..D1, 0x..92, 0x50000010; depth 2,1,0; o_err=0.
REQ-029 Return with depth 0 in bank 0 -> CPSR unchanged, o_err=1 and sticky until reset.
REQ-030 Entry and return same cycle; MSR CPSR mode 0x15 (unmatched); en=0 with requests; rst_n low mid-nest -> entry wins; bank unchanged + o_err; no state change; all reset values next cycle.

Source files
------------

// File: rtl/psr_pkg.sv
// psr_pkg: shared mode-code table, PSR bit positions, field masks and the PSR packing helper.
// No ports; imported by psr_mode_dec and psr_bank.
package psr_pkg;
  localparam int NUM_MODES = 6;
  localparam logic [NUM_MODES-1:0][4:0] MODE_CODE = {5'b11011, 5'b10111, 5'b10011, 5'b10010, 5'b10001, 5'b10000};
  localparam int PSR_NZCV_LSB = 28;
  localparam int PSR_I_BIT = 7;
  localparam int PSR_F_BIT = 6;
  localparam logic [31:0] PSR_FLAGS_MASK = 32'hF000_0000;
  localparam logic [31:0] PSR_CTRL_MASK = 32'h0000_00DF;
  function automatic logic [31:0] psr_pack(input logic [3:0] nzcv, input logic i, input logic f, input int bank);
    logic [31:0] p;
    p = '0;
    p[PSR_NZCV_LSB +: 4] = nzcv;
    p[PSR_I_BIT] = i;
    p[PSR_F_BIT] = f;
    p[4:0] = (bank >= 0 && bank < NUM_MODES) ? MODE_CODE[bank] : 5'b0;
    return p;
  endfunction
endpackage

// File: rtl/psr_bank_if.sv
// psr_bank_if: exception/flag/MSR request bus and status outputs of psr_bank.
// master drives en and i_* requests and observes o_*; slave is the bank itself.
interface psr_bank_if #(parameter int BW = 3, parameter int DEPTH_W = 3);
  logic en;
  logic i_exc_req;
  logic [BW-1:0] i_exc_bank;
  logic i_exc_fmask;
  logic i_exc_ret;
  logic i_nzcv_flag;
  logic [3:0] i_nzcv_alu;
  logic i_xpsr_en_ex;
  logic i_xpsr_sel;
  logic [1:0] i_xpsr_field;
  logic [31:0] i_xpsr_reg;
  logic [31:0] o_xpsr_reg;
  logic [3:0] o_nzcv;
  logic [3:0] o_nzcv_next;
  logic o_irq_mask;
  logic o_fiq_mask;
  logic [BW-1:0] o_bank;
  logic o_int_mode;
  logic [DEPTH_W-1:0] o_depth;
  logic o_err;
  modport master (
    output en, i_exc_req, i_exc_bank, i_exc_fmask, i_exc_ret, i_nzcv_flag, i_nzcv_alu,
           i_xpsr_en_ex, i_xpsr_sel, i_xpsr_field, i_xpsr_reg,
    input  o_xpsr_reg, o_nzcv, o_nzcv_next, o_irq_mask, o_fiq_mask, o_bank, o_int_mode, o_depth, o_err
  );
  modport slave (
    input  en, i_exc_req, i_exc_bank, i_exc_fmask, i_exc_ret, i_nzcv_flag, i_nzcv_alu,
           i_xpsr_en_ex, i_xpsr_sel, i_xpsr_field, i_xpsr_reg,
    output o_xpsr_reg, o_nzcv, o_nzcv_next, o_irq_mask, o_fiq_mask, o_bank, o_int_mode, o_depth, o_err
  );
endinterface

// File: rtl/psr_mode_dec.sv
// psr_mode_dec: maps a 5-bit mode code to its bank index.
// Ports: mode (code in), idx (bank index out), valid (code belongs to an implemented bank).
module psr_mode_dec import psr_pkg::*; #(
  parameter int NUM_BANKS = 4,
  parameter int BW = 3
) (
  input  logic [4:0]    mode,
  output logic [BW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = 0; k <= NUM_BANKS; k++)
      if (mode == MODE_CODE[k]) begin
        idx = BW'(k);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/psr_bank.sv
// psr_bank: CPSR plus per-exception-bank SPSRs with entry/return, ALU flag update and MSR/MRS access.
// Ports: clk, rst_n (sync active-low), bus (psr_bank_if.slave: requests in, PSR/flags/mask/bank/depth/err out).
module psr_bank import psr_pkg::*; #(
  parameter int NUM_BANKS = 4,
  parameter int DEPTH_W = 3,
  parameter int BW = $clog2(NUM_BANKS + 1)
) (
  input logic clk,
  input logic rst_n,
  psr_bank_if.slave bus
);
  typedef struct packed {
    logic [3:0]    nzcv;
    logic          i;
    logic          f;
    logic [BW-1:0] bank;
  } ps_t;
  localparam ps_t PS_RST = ps_t'({4'h0, 2'b11, {BW{1'b0}}});
  ps_t cpsr;
  ps_t spsr [NUM_BANKS+1];
  logic [DEPTH_W-1:0] depth;
  logic err;
  logic [BW-1:0] dec_idx;
  logic dec_valid;
  logic msr_c, msr_s, ctrl_wr, entry_ok, entry_bad, ret_ok, ret_bad;
  logic [3:0] nzcv_next;
  logic unused_bits;
  psr_mode_dec #(.NUM_BANKS(NUM_BANKS), .BW(BW)) u_dec (
    .mode(bus.i_xpsr_reg[4:0]),
    .idx(dec_idx),
    .valid(dec_valid)
  );
  always_comb begin
    msr_c = bus.i_xpsr_en_ex & ~bus.i_xpsr_sel;
    msr_s = bus.i_xpsr_en_ex & bus.i_xpsr_sel & (cpsr.bank != '0);
    ctrl_wr = (msr_c | msr_s) & bus.i_xpsr_field[0];
    entry_ok = bus.i_exc_req & (bus.i_exc_bank != '0) & (bus.i_exc_bank <= BW'(NUM_BANKS));
    entry_bad = bus.i_exc_req & ~entry_ok;
    ret_ok = bus.i_exc_ret & ~bus.i_exc_req & (cpsr.bank != '0);
    ret_bad = bus.i_exc_ret & ~bus.i_exc_req & (cpsr.bank == '0);
    nzcv_next = (msr_c & bus.i_xpsr_field[1]) ? bus.i_xpsr_reg[PSR_NZCV_LSB +: 4] :
                bus.i_nzcv_flag ? bus.i_nzcv_alu : cpsr.nzcv;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpsr <= PS_RST;
      for (int k = 0; k <= NUM_BANKS; k++) spsr[k] <= PS_RST;
      depth <= '0;
      err <= 1'b0;
    end else if (bus.en) begin
      if (entry_ok) begin
        // Entry saves the pre-entry control state with this cycle's flags; re-entry overwrites, no stacking.
        spsr[bus.i_exc_bank] <= {nzcv_next, cpsr.i, cpsr.f, cpsr.bank};
        cpsr <= {nzcv_next, 1'b1, cpsr.f | bus.i_exc_fmask, bus.i_exc_bank};
        depth <= &depth ? depth : depth + DEPTH_W'(1);
        err <= err | (&depth);
      end else if (entry_bad) begin
        err <= 1'b1;
      end else if (ret_ok) begin
        // Return restores CPSR wholesale; concurrent ALU/MSR updates are dropped.
        cpsr <= spsr[cpsr.bank];
        depth <= (depth == '0) ? depth : depth - DEPTH_W'(1);
        err <= err | (depth == '0);
      end else begin
        cpsr.nzcv <= nzcv_next;
        if (msr_c & bus.i_xpsr_field[0]) begin
          cpsr.i <= bus.i_xpsr_reg[PSR_I_BIT];
          cpsr.f <= bus.i_xpsr_reg[PSR_F_BIT];
          if (dec_valid) cpsr.bank <= dec_idx;
        end
        if (msr_s & bus.i_xpsr_field[1]) spsr[cpsr.bank].nzcv <= bus.i_xpsr_reg[PSR_NZCV_LSB +: 4];
        if (msr_s & bus.i_xpsr_field[0]) begin
          spsr[cpsr.bank].i <= bus.i_xpsr_reg[PSR_I_BIT];
          spsr[cpsr.bank].f <= bus.i_xpsr_reg[PSR_F_BIT];
          if (dec_valid) spsr[cpsr.bank].bank <= dec_idx;
        end
        err <= err | ret_bad | (ctrl_wr & ~dec_valid);
      end
    end
  end
  assign bus.o_nzcv = cpsr.nzcv;
  assign bus.o_nzcv_next = nzcv_next;
  assign bus.o_irq_mask = cpsr.i;
  assign bus.o_fiq_mask = cpsr.f;
  assign bus.o_bank = cpsr.bank;
  assign bus.o_int_mode = cpsr.bank != '0;
  assign bus.o_depth = depth;
  assign bus.o_err = err;
  // The user bank has no SPSR, so an SPSR read there reflects CPSR.
  assign bus.o_xpsr_reg = (bus.i_xpsr_sel && cpsr.bank != '0) ?
    psr_pack(spsr[cpsr.bank].nzcv, spsr[cpsr.bank].i, spsr[cpsr.bank].f, int'(spsr[cpsr.bank].bank)) :
    psr_pack(cpsr.nzcv, cpsr.i, cpsr.f, int'(cpsr.bank));
  assign unused_bits = ^{bus.i_xpsr_reg[27:8], bus.i_xpsr_reg[5]};
endmodule

// File: tb/tb_psr_bank.sv
// tb_psr_bank: directed checks of reset, entry/return nesting, MSR/MRS, error cases and reset override.
module tb_psr_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_asrt = 0;
  int n_fail = 0;
  psr_bank_if #(.BW(3), .DEPTH_W(3)) bus();
  psr_bank #(.NUM_BANKS(4), .DEPTH_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.en = 1'b1;
    bus.i_exc_req = 1'b0;
    bus.i_exc_bank = '0;
    bus.i_exc_fmask = 1'b0;
    bus.i_exc_ret = 1'b0;
    bus.i_nzcv_flag = 1'b0;
    bus.i_nzcv_alu = '0;
    bus.i_xpsr_en_ex = 1'b0;
    bus.i_xpsr_sel = 1'b0;
    bus.i_xpsr_field = '0;
    bus.i_xpsr_reg = '0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mrs(input string tag, input logic sel, input logic [31:0] exp);
    bus.i_xpsr_sel = sel;
    #1;
    chk(tag, bus.o_xpsr_reg, exp);
    bus.i_xpsr_sel = 1'b0;
    #1;
  endtask
  task automatic status(input string tag, input logic [31:0] cpsr, input int dep, input logic err);
    mrs({tag, "_cpsr"}, 1'b0, cpsr);
    chk({tag, "_depth"}, 32'(bus.o_depth), 32'(dep));
    chk({tag, "_err"}, 32'(bus.o_err), 32'(err));
  endtask
  task automatic entry(input logic [2:0] b, input logic fm);
    bus.i_exc_req = 1'b1;
    bus.i_exc_bank = b;
    bus.i_exc_fmask = fm;
    step();
    idle();
  endtask
  task automatic ret();
    bus.i_exc_ret = 1'b1;
    step();
    idle();
  endtask
  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    status("rst", 32'h0000_00D0, 0, 1'b0);
    chk("rst_bank", 32'(bus.o_bank), 32'd0);
    chk("rst_irq", 32'(bus.o_irq_mask), 32'd1);
    chk("rst_fiq", 32'(bus.o_fiq_mask), 32'd1);
    chk("rst_nzcv", 32'(bus.o_nzcv), 32'd0);
    chk("rst_intmode", 32'(bus.o_int_mode), 32'd0);
    mrs("rst_spsr_user", 1'b1, 32'h0000_00D0);
    bus.i_xpsr_en_ex = 1'b1;
    bus.i_xpsr_field = 2'b11;
    bus.i_xpsr_reg = 32'hA000_0010;
    #1;
    chk("msr_nzcv_next", 32'(bus.o_nzcv_next), 32'hA);
    step();
    idle();
    status("msr", 32'hA000_0010, 0, 1'b0);
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'b0101;
    #1;
    chk("alu_nzcv_next", 32'(bus.o_nzcv_next), 32'h5);
    chk("alu_nzcv_reg", 32'(bus.o_nzcv), 32'hA);
    entry(3'd2, 1'b0);
    status("e2", 32'h5000_0092, 1, 1'b0);
    mrs("e2_spsr", 1'b1, 32'h5000_0010);
    chk("e2_bank", 32'(bus.o_bank), 32'd2);
    chk("e2_intmode", 32'(bus.o_int_mode), 32'd1);
    entry(3'd1, 1'b1);
    status("e1", 32'h5000_00D1, 2, 1'b0);
    mrs("e1_spsr", 1'b1, 32'h5000_0092);
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'hF;
    ret();
    status("r1", 32'h5000_0092, 1, 1'b0);
    ret();
    status("r2", 32'h5000_0010, 0, 1'b0);
    bus.i_exc_ret = 1'b1;
    entry(3'd3, 1'b0);
    status("er", 32'h5000_0093, 1, 1'b0);
    mrs("er_spsr", 1'b1, 32'h5000_0010);
    ret();
    status("er_r", 32'h5000_0010, 0, 1'b0);
    ret();
    status("r_user", 32'h5000_0010, 0, 1'b1);
    step();
    chk("err_sticky", 32'(bus.o_err), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    status("rst2", 32'h0000_00D0, 0, 1'b0);
    bus.i_xpsr_en_ex = 1'b1;
    bus.i_xpsr_field = 2'b01;
    bus.i_xpsr_reg = 32'h0000_0015;
    step();
    idle();
    status("msr_badmode", 32'h0000_0010, 0, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'hF;
    entry(3'd5, 1'b0);
    status("bad_bank5", 32'h0000_00D0, 0, 1'b1);
    entry(3'd0, 1'b0);
    status("bad_bank0", 32'h0000_00D0, 0, 1'b1);
    bus.en = 1'b0;
    bus.i_exc_req = 1'b1;
    bus.i_exc_bank = 3'd2;
    bus.i_xpsr_en_ex = 1'b1;
    bus.i_xpsr_field = 2'b11;
    bus.i_xpsr_reg = 32'hF000_0013;
    step();
    idle();
    status("en0", 32'h0000_00D0, 0, 1'b1);
    entry(3'd4, 1'b0);
    status("e4", 32'h0000_00D7, 1, 1'b1);
    bus.i_xpsr_en_ex = 1'b1;
    bus.i_xpsr_sel = 1'b1;
    bus.i_xpsr_field = 2'b10;
    bus.i_xpsr_reg = 32'h9000_0000;
    step();
    idle();
    mrs("msr_spsr", 1'b1, 32'h9000_00D0);
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'h3;
    entry(3'd4, 1'b0);
    status("e4_again", 32'h3000_00D7, 2, 1'b1);
    mrs("e4_again_spsr", 1'b1, 32'h3000_00D7);
    rst_n = 1'b0;
    bus.i_exc_req = 1'b1;
    bus.i_exc_bank = 3'd1;
    bus.i_exc_ret = 1'b1;
    step();
    rst_n = 1'b1;
    idle();
    status("rst_mid", 32'h0000_00D0, 0, 1'b0);
    chk("rst_mid_bank", 32'(bus.o_bank), 32'd0);
    for (int k = 0; k < 7; k++) entry(3'd1, 1'b0);
    status("sat7", 32'h0000_00D1, 7, 1'b0);
    entry(3'd1, 1'b0);
    status("sat8", 32'h0000_00D1, 7, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
